// File: rtl/clk_divider_prog_if.sv
// Control/status bundle for the programmable clock divider.
// The master drives run enable and divisor loads; the slave returns the divided clock and status.
interface clk_divider_prog_if #(
  parameter int WIDTH = 8
) ();
  logic             en;
  logic [WIDTH-1:0] div_i;
  logic             div_load;
  logic             clko;
  logic             tick;
  logic             busy;
  logic             err;

  modport master (
    output en, div_i, div_load,
    input  clko, tick, busy, err
  );

  modport slave (
    input  en, div_i, div_load,
    output clko, tick, busy, err
  );
endinterface

// File: rtl/clk_divider_prog.sv
// Programmable integer clock divider with 50% duty for odd and even divisors.
// Divisor changes are queued and applied only at a period boundary.
module clk_divider_prog #(
  parameter int WIDTH    = 8,
  parameter int DIV_INIT = 5
) (
  input logic               clki,
  input logic               rst_n,
  clk_divider_prog_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] div_r, div_s;
  logic [WIDTH-1:0] pend_val_r, pend_val_s;
  logic             pend_r, pend_s;
  logic             clk_p_r, clk_p_s;
  logic             tick_r, tick_s;
  logic             err_r, err_s;
  logic             fall_n_r;
  logic             wrap_s, start_s, load_ok_s;
  logic [WIDTH-1:0] half_dn_s, half_up_s, cnt_inc_s, last_s;

  // Period geometry derived from the active divisor.
  always_comb begin
    half_dn_s = div_r >> 1;
    half_up_s = half_dn_s + {{(WIDTH-1){1'b0}}, div_r[0]};
    cnt_inc_s = cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
    last_s    = div_r - {{(WIDTH-1){1'b0}}, 1'b1};
    wrap_s    = (state_r == ST_RUN) && (cnt_r == last_s);
    load_ok_s = bus.div_load && (|bus.div_i[WIDTH-1:1]);
  end

  // Next-state, counter, divisor queue and posedge-aligned output decode.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    div_s      = div_r;
    pend_s     = pend_r;
    pend_val_s = pend_val_r;
    clk_p_s    = 1'b0;
    tick_s     = 1'b0;
    err_s      = 1'b0;
    start_s    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.en) begin
          start_s = 1'b1;
        end else begin
          cnt_s = {WIDTH{1'b0}};
        end
      end
      ST_RUN: begin
        if (wrap_s) begin
          if (bus.en) begin
            start_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
            cnt_s   = {WIDTH{1'b0}};
          end
        end else begin
          cnt_s   = cnt_inc_s;
          clk_p_s = (cnt_inc_s < half_up_s);
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {WIDTH{1'b0}};
      end
    endcase

    // A new period picks up whatever was pending before this edge.
    if (start_s) begin
      state_s = ST_RUN;
      cnt_s   = {WIDTH{1'b0}};
      clk_p_s = 1'b1;
      tick_s  = 1'b1;
      if (pend_r) begin
        div_s = pend_val_r;
      end else begin
        div_s = div_r;
      end
      pend_s = 1'b0;
    end else begin
      pend_s = pend_r;
    end

    // A load in the same cycle as a wrap is queued for the following wrap.
    if (load_ok_s) begin
      pend_s     = 1'b1;
      pend_val_s = bus.div_i;
    end else if (bus.div_load) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end

  // Posedge state register.
  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {WIDTH{1'b0}};
      div_r      <= WIDTH'(DIV_INIT);
      pend_r     <= 1'b0;
      pend_val_r <= {WIDTH{1'b0}};
      clk_p_r    <= 1'b0;
      tick_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      div_r      <= div_s;
      pend_r     <= pend_s;
      pend_val_r <= pend_val_s;
      clk_p_r    <= clk_p_s;
      tick_r     <= tick_s;
      err_r      <= err_s;
    end
  end

  // Odd divisors: cut the high phase half a cycle early on the middle count.
  always_ff @(negedge clki or negedge rst_n) begin
    if (!rst_n) begin
      fall_n_r <= 1'b0;
    end else begin
      fall_n_r <= (state_r == ST_RUN) && div_r[0] && (cnt_r == half_dn_s);
    end
  end

  assign bus.clko = clk_p_r & ~fall_n_r;
  assign bus.tick = tick_r;
  assign bus.busy = pend_r;
  assign bus.err  = err_r;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed bench for clk_divider_prog: duty/period per divisor, queued loads,
// rejected loads, enable gating and asynchronous reset.
module tb_clk_divider_prog;

  logic clki;
  logic rst_n;
  int   n_asserts;
  int   n_fail;

  clk_divider_prog_if #(.WIDTH(8)) bus_if ();

  clk_divider_prog #(.WIDTH(8), .DIV_INIT(5)) dut (
    .clki  (clki),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clki = 1'b0;
  always #5 clki = ~clki;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clki cycle at phase c of an N-cycle period: clko is high for counts
  // below ceil(N/2) after the posedge and below floor(N/2) after the negedge.
  task automatic step(input int c, input int n);
    @(posedge clki); #1;
    chk($sformatf("clko_pos N=%0d c=%0d", n, c), bus_if.clko, (c < (n + 1) / 2) ? 1'b1 : 1'b0);
    chk($sformatf("tick N=%0d c=%0d", n, c), bus_if.tick, (c == 0) ? 1'b1 : 1'b0);
    @(negedge clki); #1;
    chk($sformatf("clko_neg N=%0d c=%0d", n, c), bus_if.clko, (c < n / 2) ? 1'b1 : 1'b0);
  endtask

  task automatic run_period(input int n);
    for (int c = 0; c < n; c++) step(c, n);
  endtask

  task automatic step_idle();
    @(posedge clki); #1;
    chk("idle_clko_pos", bus_if.clko, 1'b0);
    chk("idle_tick", bus_if.tick, 1'b0);
    @(negedge clki); #1;
    chk("idle_clko_neg", bus_if.clko, 1'b0);
  endtask

  initial begin
    n_asserts       = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    bus_if.en       = 1'b1;
    bus_if.div_i    = 8'd0;
    bus_if.div_load = 1'b0;

    // Reset state
    #1;
    chk("rst_clko", bus_if.clko, 1'b0);
    chk("rst_tick", bus_if.tick, 1'b0);
    chk("rst_busy", bus_if.busy, 1'b0);
    chk("rst_err",  bus_if.err,  1'b0);
    @(negedge clki); @(negedge clki); #1;
    rst_n = 1'b1;

    // DIV_INIT=5 for 20 periods, first rise on first posedge out of reset
    for (int p = 0; p < 20; p++) run_period(5);

    // Load 4 mid-period: current period stays 5, then 4
    step(0, 5);
    bus_if.div_load = 1'b1; bus_if.div_i = 8'd4;
    step(1, 5);
    bus_if.div_load = 1'b0;
    chk("busy_after_load4", bus_if.busy, 1'b1);
    step(2, 5); step(3, 5); step(4, 5);
    chk("busy_before_wrap4", bus_if.busy, 1'b1);
    step(0, 4);
    chk("busy_clear_at_wrap4", bus_if.busy, 1'b0);
    step(1, 4); step(2, 4); step(3, 4);
    run_period(4); run_period(4);

    // Rejected loads of 1 and 0
    step(0, 4);
    bus_if.div_load = 1'b1; bus_if.div_i = 8'd1;
    step(1, 4);
    bus_if.div_load = 1'b0;
    chk("err_div1", bus_if.err, 1'b1);
    chk("busy_div1", bus_if.busy, 1'b0);
    step(2, 4);
    chk("err_single_pulse", bus_if.err, 1'b0);
    bus_if.div_load = 1'b1; bus_if.div_i = 8'd0;
    step(3, 4);
    bus_if.div_load = 1'b0;
    chk("err_div0", bus_if.err, 1'b1);
    chk("busy_div0", bus_if.busy, 1'b0);
    step(0, 4);
    chk("err_div0_cleared", bus_if.err, 1'b0);
    step(1, 4); step(2, 4); step(3, 4);
    run_period(4);

    // Switch to 6, then drop en at cnt=2
    step(0, 4);
    bus_if.div_load = 1'b1; bus_if.div_i = 8'd6;
    step(1, 4);
    bus_if.div_load = 1'b0;
    step(2, 4); step(3, 4);
    step(0, 6);
    step(1, 6);
    bus_if.en = 1'b0;
    step(2, 6); step(3, 6); step(4, 6); step(5, 6);
    step_idle(); step_idle(); step_idle();
    bus_if.en = 1'b1;
    run_period(6);

    // Load 3 then 7 in one period: 7 wins
    step(0, 6);
    bus_if.div_load = 1'b1; bus_if.div_i = 8'd3;
    step(1, 6);
    bus_if.div_i = 8'd7;
    step(2, 6);
    bus_if.div_load = 1'b0;
    step(3, 6); step(4, 6); step(5, 6);
    run_period(7);

    // Load 5 coinciding with a wrap: applies at the following wrap
    for (int c = 0; c < 7; c++) step(c, 7);
    bus_if.div_load = 1'b1; bus_if.div_i = 8'd5;
    step(0, 7);
    bus_if.div_load = 1'b0;
    chk("busy_load_at_wrap", bus_if.busy, 1'b1);
    for (int c = 1; c < 7; c++) step(c, 7);
    step(0, 5);
    chk("busy_clear_after_wrap_load", bus_if.busy, 1'b0);
    for (int c = 1; c < 5; c++) step(c, 5);

    // N=9, queue a 3, then reset while clko is high
    step(0, 5);
    bus_if.div_load = 1'b1; bus_if.div_i = 8'd9;
    step(1, 5);
    bus_if.div_load = 1'b0;
    step(2, 5); step(3, 5); step(4, 5);
    step(0, 9);
    bus_if.div_load = 1'b1; bus_if.div_i = 8'd3;
    step(1, 9);
    bus_if.div_load = 1'b0;
    chk("busy_before_reset", bus_if.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("reset_clko_immediate", bus_if.clko, 1'b0);
    chk("reset_busy", bus_if.busy, 1'b0);
    chk("reset_tick", bus_if.tick, 1'b0);
    @(negedge clki); #1;
    rst_n = 1'b1;
    run_period(5);
    chk("busy_after_reset", bus_if.busy, 1'b0);
    run_period(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_divider_prog.md
CLK_DIVIDER_PROG -- requirements
Module: clk_divider_prog

Interface
REQ-001 Parameter WIDTH, default 8: width of the divisor and internal counter.
REQ-002 Parameter DIV_INIT, default 5: divisor active out of reset; SHALL be in range 2..2^WIDTH-1.
REQ-003 Port clki  input  1: the single clock; all logic is clocked by it, with posedge and negedge both used.
REQ-004 Port rst_n  input  1: asynchronous, active-low reset.
REQ-005 Port en  input  1: run enable, sampled on clki posedge.
REQ-006 Port div_i  input  WIDTH: requested divisor N, unsigned.
REQ-007 Port div_load  input  1: single-cycle strobe that requests div_i as the new divisor.
REQ-008 Port clko  output  1: divided clock, period N clki cycles, 50% duty for odd and even N.
REQ-009 Port tick  output  1: one-clki-cycle pulse marking the start of each clko period.
REQ-010 Port busy  output  1: high while a loaded divisor is pending and not yet applied.
REQ-011 Port err  output  1: one-cycle pulse when a div_load is rejected.

Function
REQ-012 The block SHALL hold an active divisor N and a phase counter cnt that counts 0..N-1 on clki posedge and wraps to 0.
REQ-013 Even N: clko SHALL be high for exactly N/2 clki periods and low for N/2, with both edges aligned to clki posedge.
REQ-014 Odd N: clko SHALL be high for exactly N/2 clki periods (x.5), with the rising edge on a clki posedge and the falling edge on a clki negedge.
REQ-015 In every period, the clko rising edge SHALL occur on the posedge on which cnt becomes 0.
REQ-016 tick SHALL be high during the clki cycle in which cnt==0 while running.
REQ-017 On div_load with div_i>=2, div_i SHALL be captured into a pending register, and busy SHALL go high on the next posedge.
REQ-018 The pending divisor SHALL become active only at the wrap (cnt N-1 -> 0), so that no clko period is truncated or stretched; busy SHALL clear on that same posedge.
REQ-019 A second div_load while busy SHALL overwrite the pending value, and the last accepted value wins.
REQ-020 A div_load with div_i<2 SHALL be ignored, leaving the pending and active divisors unchanged, and SHALL pulse err for one cycle.
REQ-021 Every clko high and low phase SHALL be at least floor(N/2) clki periods, with no glitches, including across a divisor change.
REQ-022 When en is deasserted mid-period, the current period SHALL complete; at the wrap, cnt SHALL hold at 0, clko SHALL stay low, and tick SHALL stay low.
REQ-023 When en is reasserted while idle, the first clko rising edge and tick SHALL occur on the first posedge with en sampled high.
REQ-024 A divisor change that is pending while idle SHALL be applied on the first period after en is reasserted.
REQ-025 When div_load and a wrap occur in the same cycle, the current wrap SHALL use the old pending state, and the new value SHALL apply at the following wrap.

Reset
REQ-026 rst_n low SHALL asynchronously force: cnt=0, clko=0, tick=0, busy=0, err=0, N=DIV_INIT, and the pending register cleared; negedge-domain state SHALL also be cleared.
REQ-027 After rst_n release with en high, the first clko rising edge SHALL occur on the first posedge at which rst_n is sampled high.
REQ-028 Reset asserted mid-period SHALL drive clko low immediately, and any pending divisor SHALL be lost.

Verification
REQ-029 Run with DIV_INIT=5 and en=1 for 20 periods -> clko period 5 clki cycles, high for 2.5 cycles, tick once every 5 cycles.
REQ-030 Pulse div_load with div_i=4 at cnt=1 -> busy high until the wrap; that period stays 5 cycles; subsequent periods are 4 cycles, high for 2.
REQ-031 Pulse div_load with div_i=1, then with div_i=0 -> err pulses once for each; the period stays unchanged and busy stays 0.
REQ-032 Drop en at cnt=2 with N=6 -> the period completes; clko stays 0 and cnt stays 0; re-raising en gives a rising edge on the next posedge.
REQ-033 Load 3 and then 7 within one period -> the next period is 7 cycles and 3 is never applied.
REQ-034 Assert rst_n low while clko is high with N=9 -> clko goes to 0 immediately; after release the period is DIV_INIT.
